// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Phase codes are {sa,sb}; the next-state tables are indexed by the current code.
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } phase_t;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 3;

  // Forward order S00->S01->S11->S10->S00; reverse is the opposite walk.
  localparam phase_t FWD_NEXT [4] = '{S01, S11, S00, S10};
  localparam phase_t REV_NEXT [4] = '{S10, S00, S11, S01};

endpackage

// File: rtl/quad_step_decoder_if.sv
// Pin-side and counter-side signals of the quadrature decoder.
// master drives the encoder pins and preset; slave is the decoder itself.
interface quad_step_decoder_if #(
  parameter int WIDTH = 4
) ();
  logic             phase_a;
  logic             phase_b;
  logic             index;
  logic [WIDTH-1:0] preset_in;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err;

  modport master (
    output phase_a, phase_b, index, preset_in,
    input  up, down, load, load_val, err
  );

  modport slave (
    input  phase_a, phase_b, index, preset_in,
    output up, down, load, load_val, err
  );
endinterface

// File: rtl/qdec_sync_filter.sv
// One input: SYNC_STAGES-deep synchronizer, plus a stability filter when
// QDEC_FILTER_EN is defined (output follows only levels held FILTER_CYCLES cycles).
module qdec_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("qdec_sync_filter: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES) + 1;

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive cycles the synchronized level differs from
  // the accepted one; any return to the accepted level restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) filt_d = sync_q[SYNC_STAGES-1];
      else                                 cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = filt_q;
`else
  assign q = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: x4 phase decode into up/down strobes, index edge into
// load/load_val, illegal jumps into err. Optional input filter: QDEC_FILTER_EN.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int WIDTH         = 4
) (
  input logic                clk,
  input logic                reset,
  quad_step_decoder_if.slave bus
);

  logic sa, sb, si;

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES))
    u_sync_a (.clk(clk), .reset(reset), .d(bus.phase_a), .q(sa));
  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES))
    u_sync_b (.clk(clk), .reset(reset), .d(bus.phase_b), .q(sb));
  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES))
    u_sync_i (.clk(clk), .reset(reset), .d(bus.index), .q(si));

  phase_t           state_q, state_d, sample;
  logic             primed_q, primed_d;
  logic             idx_q, idx_d;
  logic             up_q, up_d, down_q, down_d, load_q, load_d, err_q, err_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             fwd, rev, jump, idx_rise;

  always_comb begin
    sample     = phase_t'({sa, sb});
    fwd        = (sample == FWD_NEXT[state_q]);
    rev        = (sample == REV_NEXT[state_q]);
    jump       = (sample != state_q) && !fwd && !rev;
    idx_rise   = si && !idx_q;
    state_d    = sample;
    idx_d      = si;
    primed_d   = 1'b1;
    up_d       = 1'b0;
    down_d     = 1'b0;
    load_d     = 1'b0;
    err_d      = 1'b0;
    load_val_d = load_val_q;
    // The first sample after reset only seeds state and index history.
    if (primed_q) begin
      load_d = idx_rise;
      err_d  = jump;
      up_d   = fwd && !idx_rise;
      down_d = rev && !idx_rise;
      if (idx_rise) load_val_d = bus.preset_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S00;
      primed_q   <= 1'b0;
      idx_q      <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      load_val_q <= '0;
    end else begin
      state_q    <= state_d;
      primed_q   <= primed_d;
      idx_q      <= idx_d;
      up_q       <= up_d;
      down_q     <= down_d;
      load_q     <= load_d;
      err_q      <= err_d;
      load_val_q <= load_val_d;
    end
  end

  assign bus.up       = up_q;
  assign bus.down     = down_q;
  assign bus.load     = load_q;
  assign bus.err      = err_q;
  assign bus.load_val = load_val_q;

endmodule
